// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary helpers for the Gray codec pipeline.
// Pure package: no latency, no flow control.
// Used by RTL for slice sizing, encode and error checking.
package gray_pkg;

    localparam int MODE_DECODE = 0;
    localparam int MODE_ENCODE = 1;

    function automatic int slice_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int popcount(input logic [31:0] x);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline register of the Gray codec: resolves slice IDX (decode) or encodes (IDX 0).
// Latency: 1 cycle.
// Backpressure: loads when empty or when downstream takes the held word (dn_rdy).
module gray_pipe_stage
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1,
    parameter int MODE   = MODE_DECODE,
    parameter int IDX    = 0
) (
    input  logic             clk_de,
    input  logic             rst_de_n,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             up_run,
    input  logic             dn_rdy,
    output logic             vld,
    output logic [WIDTH-1:0] dat,
    output logic             run
`ifdef GRAY_ERR_CHECK_EN
    ,
    input  logic             up_err,
    output logic             err
`endif
);

    localparam int SW     = slice_w(WIDTH, STAGES);
    localparam int HI     = WIDTH - 1 - IDX * SW;
    localparam int LO_RAW = WIDTH - (IDX + 1) * SW;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic             ld;
    logic             acc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] nxt;

    assign ld = !vld || dn_rdy;

    // Bits outside [LO,HI] pass through untouched; an empty slice just forwards the running bit.
    always_comb begin
        acc = up_run;
        dec = up_dat;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
                acc    = acc ^ up_dat[i];
                dec[i] = acc;
            end
        end
        if (MODE == MODE_ENCODE) begin
            nxt = (IDX == 0) ? WIDTH'(bin2gray(32'(up_dat))) : up_dat;
        end else begin
            nxt = dec;
        end
    end

    always_ff @(posedge clk_de or negedge rst_de_n) begin
        if (!rst_de_n) begin
            vld <= 1'b0;
            dat <= '0;
            run <= 1'b0;
        end else if (ld) begin
            vld <= up_vld;
            if (up_vld) begin
                dat <= nxt;
                run <= acc;
            end
        end
    end

`ifdef GRAY_ERR_CHECK_EN
    always_ff @(posedge clk_de or negedge rst_de_n) begin
        if (!rst_de_n) begin
            err <= 1'b0;
        end else if (ld && up_vld) begin
            err <= up_err;
        end
    end
`endif

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter; optional adjacency check under GRAY_ERR_CHECK_EN.
// Latency: STAGES cycles, one word per cycle.
// Backpressure: out_ready ripples combinationally through the valid chain to in_ready.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1,
    parameter int MODE   = MODE_DECODE
) (
    input  logic             clk_de,
    input  logic             rst_de_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef GRAY_ERR_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    logic [STAGES:0]  v_c;
    logic [STAGES:0]  r_c;
    logic [WIDTH-1:0] d_c [STAGES+1];
    logic [STAGES-1:0] rdy;
    logic             rdy_acc;
    logic             unused_run;

    assign v_c[0] = in_valid;
    assign r_c[0] = 1'b0;
    assign d_c[0] = in_data;

    // rdy[k] is "downstream of stage k takes this cycle"; the final value is in_ready.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k]  = rdy_acc;
            rdy_acc = !v_c[k+1] || rdy_acc;
        end
        in_ready = rdy_acc;
    end

`ifdef GRAY_ERR_CHECK_EN
    logic [STAGES:0]  e_c;
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic [WIDTH-1:0] chk_gray;

    always_comb begin
        chk_gray = (MODE == MODE_ENCODE) ? WIDTH'(bin2gray(32'(in_data))) : in_data;
        e_c[0]   = have_prev_q && (popcount(32'(chk_gray ^ prev_q)) >= 2);
    end

    always_ff @(posedge clk_de or negedge rst_de_n) begin
        if (!rst_de_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            prev_q      <= chk_gray;
            have_prev_q <= 1'b1;
        end
    end

    assign gray_err = e_c[STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_pipe_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .MODE  (MODE),
            .IDX   (k)
        ) u_stage (
            .clk_de  (clk_de),
            .rst_de_n(rst_de_n),
            .up_vld  (v_c[k]),
            .up_dat  (d_c[k]),
            .up_run  (r_c[k]),
            .dn_rdy  (rdy[k]),
            .vld     (v_c[k+1]),
            .dat     (d_c[k+1]),
            .run     (r_c[k+1])
`ifdef GRAY_ERR_CHECK_EN
            ,
            .up_err  (e_c[k]),
            .err     (e_c[k+1])
`endif
        );
    end

    assign out_valid  = v_c[STAGES];
    assign out_data   = d_c[STAGES];
    assign unused_run = r_c[STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench: six codec configurations share one stimulus stream; each has its own scoreboard
// fed by a spec-level model (prefix-XOR decode, shift-XOR encode, Hamming-distance check).
module tb_gray_codec_pipe;

    localparam int NI = 6;

    function automatic int st_of(input int i);
        case (i)
            0: return 2;
            1: return 2;
            2: return 8;
            3: return 1;
            4: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int md_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic       clk_de = 1'b0;
    logic       rst_de_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       ir [NI];
    logic       ov [NI];
    logic [7:0] od [NI];
`ifdef GRAY_ERR_CHECK_EN
    logic       ge [NI];
    logic       last_ge0;
`endif

    always #5 clk_de = ~clk_de;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gray_codec_pipe #(
            .WIDTH (8),
            .STAGES(st_of(g)),
            .MODE  (md_of(g))
        ) u_dut (
            .clk_de   (clk_de),
            .rst_de_n (rst_de_n),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g])
`ifdef GRAY_ERR_CHECK_EN
            ,
            .gray_err (ge[g])
`endif
        );
    end

    int         total = 0;
    int         bad = 0;
    logic [8:0] sb [NI][32];
    int         wp [NI];
    int         rp [NI];
    int         nout [NI];
    bit         hv [NI];
    logic [7:0] prevg [NI];
    bit         hold_v [NI];
    logic [8:0] hold_x [NI];
    bit         acc_s [NI];
    bit         ir_s [NI];

    function automatic logic [7:0] ref_conv(input int md, input logic [7:0] x);
        logic [7:0] b;
        if (md == 1) return x ^ (x >> 1);
        b = '0;
        for (int s = 0; s < 8; s++) b = b ^ (x >> s);
        return b;
    endfunction

    task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d got=%0h exp=%0h", tag, i, got, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] g;
        logic       e;
        logic       cur_e;
        for (int i = 0; i < NI; i++) begin
            ir_s[i]  = ir[i];
            acc_s[i] = 1'b0;
`ifdef GRAY_ERR_CHECK_EN
            cur_e = ge[i];
`else
            cur_e = 1'b0;
`endif
            if (!rst_de_n) begin
                wp[i] = 0; rp[i] = 0; hv[i] = 1'b0; hold_v[i] = 1'b0;
            end else begin
                if (hold_v[i]) begin
                    check("hold_vld", i, 32'(ov[i]), 32'd1);
                    check("hold_dat", i, 32'(od[i]), 32'(hold_x[i][7:0]));
                    check("hold_err", i, 32'(cur_e), 32'(hold_x[i][8]));
                end
                if (ov[i]) begin
                    check("spurious", i, 32'(wp[i] != rp[i]), 32'd1);
                    if (wp[i] != rp[i]) begin
                        check("data", i, 32'(od[i]), 32'(sb[i][rp[i] % 32][7:0]));
`ifdef GRAY_ERR_CHECK_EN
                        check("err", i, 32'(cur_e), 32'(sb[i][rp[i] % 32][8]));
`endif
                        if (out_ready) begin
                            rp[i]++;
                            nout[i]++;
                        end
                    end
                    hold_v[i] = !out_ready;
                    hold_x[i] = {cur_e, od[i]};
                end else begin
                    hold_v[i] = 1'b0;
                end
                if (in_valid && ir[i]) begin
                    g = (md_of(i) == 1) ? (in_data ^ (in_data >> 1)) : in_data;
                    e = hv[i] && ($countones(g ^ prevg[i]) >= 2);
                    sb[i][wp[i] % 32] = {e, ref_conv(md_of(i), in_data)};
                    wp[i]++;
                    prevg[i] = g;
                    hv[i]    = 1'b1;
                    acc_s[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk_de);
        monitor();
        @(posedge clk_de);
        #1;
    endtask

    task automatic one_beat(input logic [7:0] din, input logic [7:0] exp_dec);
        int         lat [NI];
        logic [7:0] cap [NI];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = din;
        cycle();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0;
            cap[i] = '0;
        end
        for (int n = 1; n <= 12; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (lat[i] == 0 && ov[i]) begin
                    lat[i] = n;
                    cap[i] = od[i];
`ifdef GRAY_ERR_CHECK_EN
                    if (i == 0) last_ge0 = ge[0];
`endif
                end
            end
            cycle();
        end
        for (int i = 0; i < NI; i++) begin
            check("latency", i, 32'(lat[i]), 32'(st_of(i)));
            check("value", i, 32'(cap[i]), 32'((md_of(i) == 1) ? ref_conv(1, din) : exp_dec));
        end
    endtask

    task automatic drain_and_check_empty(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) cycle();
        for (int i = 0; i < NI; i++) check(tag, i, 32'(wp[i] - rp[i]), 32'd0);
    endtask

    initial begin
        int n0 [NI];
        int k;
        int cyc;
        int seen [NI];

        for (int i = 0; i < NI; i++) begin
            wp[i] = 0; rp[i] = 0; nout[i] = 0; hv[i] = 1'b0; hold_v[i] = 1'b0;
        end
        rst_de_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (3) cycle();
        for (int i = 0; i < NI; i++) begin
            check("rst_out_valid", i, 32'(ov[i]), 32'd0);
            check("rst_out_data", i, 32'(od[i]), 32'd0);
        end
        rst_de_n = 1'b1;
        cycle();
        for (int i = 0; i < NI; i++) begin
            check("post_rst_in_ready", i, 32'(ir[i]), 32'd1);
            check("post_rst_out_valid", i, 32'(ov[i]), 32'd0);
            check("post_rst_out_data", i, 32'(od[i]), 32'd0);
`ifdef GRAY_ERR_CHECK_EN
            check("post_rst_gray_err", i, 32'(ge[i]), 32'd0);
`endif
        end

        // Directed decode values with latency measurement on every configuration.
        one_beat(8'hC0, 8'h80);
`ifdef GRAY_ERR_CHECK_EN
        check("err_first_beat", 0, 32'(last_ge0), 32'd0);
`endif
        one_beat(8'h01, 8'h01);
`ifdef GRAY_ERR_CHECK_EN
        check("err_c0_01", 0, 32'(last_ge0), 32'd1);
`endif
        one_beat(8'hFF, 8'hAA);
`ifdef GRAY_ERR_CHECK_EN
        check("err_01_ff", 0, 32'(last_ge0), 32'd1);
`endif

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < NI; i++) n0[i] = nout[i];
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            in_valid = 1'b1;
            in_data  = 8'(v);
            cycle();
            for (int i = 0; i < NI; i++) check("sweep_accept", i, 32'(acc_s[i]), 32'd1);
        end
        drain_and_check_empty("sweep_empty");
        for (int i = 0; i < NI; i++) check("sweep_count", i, 32'(nout[i] - n0[i]), 32'd256);

        // Backpressure: 10 beats held per inst 0's handshake, out_ready low for 5 cycles.
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 60) begin
            in_valid  = 1'b1;
            in_data   = 8'(8'h30 + k);
            out_ready = !(cyc >= 4 && cyc < 9);
            cycle();
            if (cyc == 8) begin
                check("bp_in_ready", 0, 32'(ir_s[0]), 32'd0);
                check("bp_in_ready", 3, 32'(ir_s[3]), 32'd0);
            end
            if (acc_s[0]) k++;
            cyc++;
        end
        check("bp_beats", 0, 32'(k), 32'd10);
        drain_and_check_empty("bp_empty");

        // Randomised traffic with random backpressure.
        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain_and_check_empty("rand_empty");

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        cycle();
        in_data = 8'hA5;
        cycle();
        in_valid = 1'b0;
        #2;
        rst_de_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_rst_out_valid", i, 32'(ov[i]), 32'd0);
            check("async_rst_out_data", i, 32'(od[i]), 32'd0);
            check("async_rst_in_ready", i, 32'(ir[i]), 32'd1);
        end
        cycle();
        cycle();
        rst_de_n = 1'b1;
        for (int i = 0; i < NI; i++) seen[i] = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            for (int i = 0; i < NI; i++) if (ov[i]) seen[i]++;
        end
        for (int i = 0; i < NI; i++) check("stale_beat", i, 32'(seen[i]), 32'd0);

        // Adjacency sequence right after reset.
        one_beat(8'h01, 8'h01);
`ifdef GRAY_ERR_CHECK_EN
        check("err_seq0", 0, 32'(last_ge0), 32'd0);
`endif
        one_beat(8'h03, 8'h02);
`ifdef GRAY_ERR_CHECK_EN
        check("err_seq1", 0, 32'(last_ge0), 32'd0);
`endif
        one_beat(8'h03, 8'h02);
`ifdef GRAY_ERR_CHECK_EN
        check("err_seq2", 0, 32'(last_ge0), 32'd0);
`endif
        one_beat(8'h00, 8'h00);
`ifdef GRAY_ERR_CHECK_EN
        check("err_seq3", 0, 32'(last_ge0), 32'd1);
`endif
        drain_and_check_empty("final_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
